// File: rtl/sprite_engine.sv
// sprite_engine: N-channel sprite pixel engine.
//   Holds per-sprite X/Y/CTRL/colour-key registers (shadow copy written by the CPU,
//   active copy loaded at frame start), generates per-sprite ROM addresses for the
//   current pixel, composes opaque sprite pixels over a background colour (index 0
//   has highest priority) and records sticky sprite-to-sprite collisions.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   MW_i, address_i, data_i  register write port; rd_data_o is the registered read
//   frame_start_i            copies shadow sprite registers into the active set
//   pixel_valid_i, x/y_pos_i current pixel
//   mem_address_o            per-sprite ROM address (sprite k at slice k)
//   mem_data_i               per-sprite ROM data, one cycle after mem_address_o
//   RGB_o, rgb_valid_o       composed pixel, 3 cycles after the pixel input
module sprite_engine #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPRITE_W    = 32,
    parameter int unsigned SPRITE_H    = 32,
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned MEM_AW      = $clog2(SPRITE_W * SPRITE_H),
    parameter int unsigned SEL_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          MW_i,
    input  logic [SEL_W+2:0]              address_i,
    input  logic [31:0]                   data_i,
    output logic [31:0]                   rd_data_o,
    input  logic                          frame_start_i,
    input  logic                          pixel_valid_i,
    input  logic [COORD_W-1:0]            x_pos_i,
    input  logic [COORD_W-1:0]            y_pos_i,
    output logic [NUM_SPRITES*MEM_AW-1:0] mem_address_o,
    input  logic [NUM_SPRITES*24-1:0]     mem_data_i,
    output logic [23:0]                   RGB_o,
    output logic                          rgb_valid_o
);

    // One extra bit so that X + SPRITE_W never wraps around the screen edge.
    localparam int unsigned CW1 = COORD_W + 1;

    // Register file
    logic [NUM_SPRITES-1:0][COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [NUM_SPRITES-1:0][COORD_W-1:0] act_x_q, act_y_q;
    logic [NUM_SPRITES-1:0][2:0]         sh_ctrl_q, sh_ctrl_d, act_ctrl_q;
    logic [NUM_SPRITES-1:0][23:0]        sh_key_q, sh_key_d, act_key_q;
    logic [23:0]                         bg_q, bg_d;
    logic [NUM_SPRITES-1:0]              coll_q, coll_d, coll_clr, coll_set;
    logic [31:0]                         rd_d;

    logic             addr_page;
    logic [SEL_W-1:0] addr_sel;
    logic [1:0]       addr_reg;
    logic             sel_ok;

    // Pipeline
    logic [CW1-1:0]                         px, py;
    logic [NUM_SPRITES-1:0]                 hit_s0, hit_s1_q, hit_s2_q;
    logic [NUM_SPRITES-1:0][MEM_AW-1:0]     addr_s0, addr_s1_q;
    logic [NUM_SPRITES-1:0][23:0]           key_s1_q, key_s2_q;
    logic                                   valid_s1_q, valid_s2_q;
    logic [NUM_SPRITES-1:0]                 opaque;
    logic                                   multi;
    logic [23:0]                            pix;

    assign addr_page = address_i[SEL_W+2];
    assign addr_sel  = address_i[SEL_W+1:2];
    assign addr_reg  = address_i[1:0];

    // Select field may encode indices with no sprite behind them.
    if ((2 ** SEL_W) > NUM_SPRITES) begin : g_sel_chk
        assign sel_ok = (32'(addr_sel) < NUM_SPRITES);
    end else begin : g_sel_all
        assign sel_ok = 1'b1;
    end

    // ---------------------------------------------------------------- register writes
    always_comb begin
        sh_x_d    = sh_x_q;
        sh_y_d    = sh_y_q;
        sh_ctrl_d = sh_ctrl_q;
        sh_key_d  = sh_key_q;
        bg_d      = bg_q;
        coll_clr  = '0;
        if (MW_i) begin
            if (!addr_page) begin
                if (sel_ok) begin
                    case (addr_reg)
                        2'd0:    sh_x_d[addr_sel]    = data_i[COORD_W-1:0];
                        2'd1:    sh_y_d[addr_sel]    = data_i[COORD_W-1:0];
                        2'd2:    sh_ctrl_d[addr_sel] = data_i[2:0];
                        default: sh_key_d[addr_sel]  = data_i[23:0];
                    endcase
                end
            end else begin
                case (addr_reg)
                    2'd0:    bg_d     = data_i[23:0];
                    2'd1:    coll_clr = data_i[NUM_SPRITES-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Set beats clear when both hit the same bit in one cycle.
    assign coll_d = (coll_q & ~coll_clr) | coll_set;

    // Read mux looks at next-state values so a write is visible on the following cycle.
    always_comb begin
        rd_d = '0;
        if (!addr_page) begin
            if (sel_ok) begin
                case (addr_reg)
                    2'd0:    rd_d[COORD_W-1:0] = sh_x_d[addr_sel];
                    2'd1:    rd_d[COORD_W-1:0] = sh_y_d[addr_sel];
                    2'd2:    rd_d[2:0]         = sh_ctrl_d[addr_sel];
                    default: rd_d[23:0]        = sh_key_d[addr_sel];
                endcase
            end
        end else begin
            case (addr_reg)
                2'd0:    rd_d[23:0]            = bg_d;
                2'd1:    rd_d[NUM_SPRITES-1:0] = coll_d;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_ctrl_q  <= '0;
            sh_key_q   <= '0;
            act_x_q    <= '0;
            act_y_q    <= '0;
            act_ctrl_q <= '0;
            act_key_q  <= '0;
            bg_q       <= '0;
            coll_q     <= '0;
            rd_data_o  <= '0;
        end else begin
            sh_x_q    <= sh_x_d;
            sh_y_q    <= sh_y_d;
            sh_ctrl_q <= sh_ctrl_d;
            sh_key_q  <= sh_key_d;
            bg_q      <= bg_d;
            coll_q    <= coll_d;
            rd_data_o <= rd_d;
            // Loading from next-state lets a write in the frame-start cycle land in both.
            if (frame_start_i) begin
                act_x_q    <= sh_x_d;
                act_y_q    <= sh_y_d;
                act_ctrl_q <= sh_ctrl_d;
                act_key_q  <= sh_key_d;
            end
        end
    end

    // ---------------------------------------------------------------- stage 0: hit test
    assign px = {1'b0, x_pos_i};
    assign py = {1'b0, y_pos_i};

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_spr
        logic [CW1-1:0] sx, sy, dx, dy, ox, oy;
        logic           in_x, in_y;

        assign sx   = {1'b0, act_x_q[k]};
        assign sy   = {1'b0, act_y_q[k]};
        assign dx   = px - sx;
        assign dy   = py - sy;
        assign in_x = (px >= sx) && (px < sx + CW1'(SPRITE_W));
        assign in_y = (py >= sy) && (py < sy + CW1'(SPRITE_H));
        assign ox   = act_ctrl_q[k][1] ? CW1'(SPRITE_W - 1) - dx : dx;
        assign oy   = act_ctrl_q[k][2] ? CW1'(SPRITE_H - 1) - dy : dy;

        assign hit_s0[k]  = act_ctrl_q[k][0] && in_x && in_y;
        assign addr_s0[k] = hit_s0[k] ? MEM_AW'(oy) * MEM_AW'(SPRITE_W) + MEM_AW'(ox) : '0;
    end

    // ---------------------------------------------------------------- stage 3: compose
    always_comb begin
        opaque = '0;
        for (int k = 0; k < int'(NUM_SPRITES); k++) begin
            opaque[k] = hit_s2_q[k] && (mem_data_i[k*24 +: 24] != key_s2_q[k]);
        end
    end

    // Descending scan so the lowest opaque index is the last assignment.
    always_comb begin
        pix = bg_q;
        for (int k = int'(NUM_SPRITES) - 1; k >= 0; k--) begin
            if (opaque[k]) pix = mem_data_i[k*24 +: 24];
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi    = |(opaque & (opaque - NUM_SPRITES'(1)));
    assign coll_set = (valid_s2_q && multi) ? opaque : '0;

    assign mem_address_o = addr_s1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_s1_q   <= '0;
            hit_s1_q    <= '0;
            key_s1_q    <= '0;
            valid_s1_q  <= 1'b0;
            hit_s2_q    <= '0;
            key_s2_q    <= '0;
            valid_s2_q  <= 1'b0;
            RGB_o       <= '0;
            rgb_valid_o <= 1'b0;
        end else begin
            addr_s1_q   <= addr_s0;
            hit_s1_q    <= hit_s0;
            key_s1_q    <= act_key_q;
            valid_s1_q  <= pixel_valid_i;
            hit_s2_q    <= hit_s1_q;
            key_s2_q    <= key_s1_q;
            valid_s2_q  <= valid_s1_q;
            rgb_valid_o <= valid_s2_q;
            if (valid_s2_q) RGB_o <= pix;
        end
    end

endmodule
